// File: rtl/mux_pipe_n_pkg.sv
// Shared types and constants for the pipelined N-input mux.
// Holds the entry carried through the skid buffer and the buffer occupancy states.
package mux_pkg;

    localparam int MUX_MAX_IN = 16;
    localparam int ERR_CNT_W  = 8;
    // Widest data path the entry struct can carry; instances use the low WIDTH bits.
    localparam int MUX_MAX_W  = 64;

    typedef struct packed {
        logic [MUX_MAX_W-1:0] data;
        logic                 erro;
    } mux_entry_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mux_pipe_n_if.sv
// Handshake bundle for mux_pipe_n: producer side (ctrl/entradas/in_valid/in_ready),
// consumer side (saida/out_erro/out_valid/out_ready) and the flush request.
interface mux_pipe_n_if #(
    parameter int WIDTH = 32,
    parameter int N_IN  = 3
);
    localparam int SEL_W = $clog2(N_IN);

    logic [SEL_W-1:0]      ctrl;
    logic [N_IN*WIDTH-1:0] entradas;
    logic                  in_valid;
    logic                  in_ready;
    logic                  flush;
    logic [WIDTH-1:0]      saida;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_erro;

    // Environment side: drives the producer/consumer controls, observes the mux.
    modport master (
        output ctrl, entradas, in_valid, flush, out_ready,
        input  in_ready, saida, out_valid, out_erro
    );

    modport slave (
        input  ctrl, entradas, in_valid, flush, out_ready,
        output in_ready, saida, out_valid, out_erro
    );

endinterface

// File: rtl/mux_pipe_n_skid_buf.sv
// Two-entry FIFO (main + skid register) with valid/ready on both sides and flush.
// in_ready is a flop so the upstream ready path never sees downstream logic.
module skid_buf
    import mux_pkg::*;
#(
    parameter int ENTRY_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic [ENTRY_W-1:0] in_data_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    output logic [ENTRY_W-1:0] out_data_o,
    output logic               out_valid_o,
    input  logic               out_ready_i
);

    buf_state_e         state_q, state_d;
    logic               in_ready_q;
    logic [ENTRY_W-1:0] main_q, main_d;
    logic [ENTRY_W-1:0] skid_q, skid_d;
    logic               accept;
    logic               pop;

    assign accept = in_valid_i && in_ready_q && !flush_i;
    assign pop    = (state_q != BUF_EMPTY) && out_ready_i && !flush_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = BUF_EMPTY;
        end else begin
            unique case (state_q)
                BUF_EMPTY: begin
                    if (accept) begin
                        main_d  = in_data_i;
                        state_d = BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (accept && pop) begin
                        main_d = in_data_i;
                    end else if (accept) begin
                        skid_d  = in_data_i;
                        state_d = BUF_FULL;
                    end else if (pop) begin
                        state_d = BUF_EMPTY;
                    end
                end
                BUF_FULL: begin
                    // in_ready is low here, so only a pop can change occupancy.
                    if (pop) begin
                        main_d  = skid_q;
                        state_d = BUF_ONE;
                    end
                end
                default: state_d = BUF_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= BUF_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != BUF_FULL);
        end
    end

    // Payload registers carry no reset; the valid state masks them downstream.
    always_ff @(posedge clk_i) begin
        main_q <= main_d;
        skid_q <= skid_d;
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = (state_q != BUF_EMPTY);
    assign out_data_o  = main_q;

endmodule

// File: rtl/mux_pipe_n.sv
// N-input selector with one-cycle registered output and a 2-entry skid buffer.
// Optional MUX_PIPE_ERR_CNT_EN adds a saturating count of illegal-ctrl accepts.
module mux_pipe_n
    import mux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N_IN  = 3,
    parameter int SEL_W = $clog2(N_IN)
) (
    input  logic               clock,
    input  logic               reset,
    mux_pipe_n_if.slave        bus
`ifdef MUX_PIPE_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] erro_cnt
`endif
);

    logic [SEL_W-1:0] ctrl_s;
    mux_entry_t       sel_s;
    mux_entry_t       out_s;
    logic             out_valid;

    assign ctrl_s = bus.ctrl;

    // Out-of-range selectors yield zero data tagged with erro.
    always_comb begin
        sel_s      = '0;
        sel_s.erro = 1'b1;
        for (int i = 0; i < N_IN; i++) begin
            if (int'(ctrl_s) == i) begin
                sel_s.data = MUX_MAX_W'(bus.entradas[i*WIDTH +: WIDTH]);
                sel_s.erro = 1'b0;
            end
        end
    end

    skid_buf #(
        .ENTRY_W($bits(mux_entry_t))
    ) u_skid (
        .clk_i      (clock),
        .rst_i      (reset),
        .flush_i    (bus.flush),
        .in_data_i  (sel_s),
        .in_valid_i (bus.in_valid),
        .in_ready_o (bus.in_ready),
        .out_data_o (out_s),
        .out_valid_o(out_valid),
        .out_ready_i(bus.out_ready)
    );

    assign bus.out_valid = out_valid;
    assign bus.saida     = out_valid ? WIDTH'(out_s.data) : '0;
    assign bus.out_erro  = out_valid && out_s.erro;

`ifdef MUX_PIPE_ERR_CNT_EN
    logic                 accept;
    logic [ERR_CNT_W-1:0] erro_cnt_q, erro_cnt_d;

    assign accept = bus.in_valid && bus.in_ready && !bus.flush;

    always_comb begin
        erro_cnt_d = erro_cnt_q;
        if (accept && sel_s.erro) begin
            erro_cnt_d = sat_inc(erro_cnt_q);
        end
    end

    // Flush leaves the count alone; only reset clears it.
    always_ff @(posedge clock) begin
        if (reset) begin
            erro_cnt_q <= '0;
        end else begin
            erro_cnt_q <= erro_cnt_d;
        end
    end

    assign erro_cnt = erro_cnt_q;
`endif

endmodule

// File: tb/tb_mux_pipe_n.sv
// Directed bench for mux_pipe_n: a 3x32 instance and a 16x8 instance share clock and reset.
module tb_mux_pipe_n;
    import mux_pkg::*;

    logic clock = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clock = ~clock;

    mux_pipe_n_if #(.WIDTH(32), .N_IN(3))  bus_a ();
    mux_pipe_n_if #(.WIDTH(8),  .N_IN(16)) bus_b ();

`ifdef MUX_PIPE_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] cnt_a;
    logic [ERR_CNT_W-1:0] cnt_b;
`endif

    mux_pipe_n #(.WIDTH(32), .N_IN(3)) u_dut_a (
        .clock(clock),
        .reset(reset),
        .bus  (bus_a)
`ifdef MUX_PIPE_ERR_CNT_EN
        ,
        .erro_cnt(cnt_a)
`endif
    );

    mux_pipe_n #(.WIDTH(8), .N_IN(16)) u_dut_b (
        .clock(clock),
        .reset(reset),
        .bus  (bus_b)
`ifdef MUX_PIPE_ERR_CNT_EN
        ,
        .erro_cnt(cnt_b)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic v, input logic [31:0] d,
                         input logic e, input logic r);
        chk({tag, ".out_valid"}, 32'(bus_a.out_valid), 32'(v));
        chk({tag, ".saida"},     bus_a.saida,          d);
        chk({tag, ".out_erro"},  32'(bus_a.out_erro),  32'(e));
        chk({tag, ".in_ready"},  32'(bus_a.in_ready),  32'(r));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset              = 1'b1;
        bus_a.ctrl         = '0;
        bus_a.entradas     = {32'h33, 32'h22, 32'h11};
        bus_a.in_valid     = 1'b0;
        bus_a.flush        = 1'b0;
        bus_a.out_ready    = 1'b0;
        bus_b.ctrl         = '0;
        for (int i = 0; i < 16; i++) bus_b.entradas[i*8 +: 8] = 8'(8'hA0 + i);
        bus_b.in_valid     = 1'b0;
        bus_b.flush        = 1'b0;
        bus_b.out_ready    = 1'b0;

        tick();
        tick();
        chk_a("rst", 1'b0, 32'h0, 1'b0, 1'b1);
        chk("rst_b.out_valid", 32'(bus_b.out_valid), 32'h0);
        chk("rst_b.saida",     32'(bus_b.saida),     32'h0);
        chk("rst_b.in_ready",  32'(bus_b.in_ready),  32'h1);
        reset = 1'b0;
        tick();
        chk_a("idle", 1'b0, 32'h0, 1'b0, 1'b1);

        // Streaming select, one entry per cycle, last selector illegal
        bus_a.out_ready = 1'b1;
        bus_a.in_valid  = 1'b1;
        bus_a.ctrl = 2'd0; tick(); chk_a("seq0", 1'b1, 32'h11, 1'b0, 1'b1);
        bus_a.ctrl = 2'd1; tick(); chk_a("seq1", 1'b1, 32'h22, 1'b0, 1'b1);
        bus_a.ctrl = 2'd2; tick(); chk_a("seq2", 1'b1, 32'h33, 1'b0, 1'b1);
        bus_a.ctrl = 2'd3; tick(); chk_a("seq3", 1'b1, 32'h00, 1'b1, 1'b1);
        bus_a.in_valid = 1'b0;
        tick(); chk_a("seq_end", 1'b0, 32'h0, 1'b0, 1'b1);

        // Back-pressure: two accepted, third held off until the buffer drains
        bus_a.out_ready = 1'b0;
        bus_a.in_valid  = 1'b1;
        bus_a.ctrl = 2'd0; tick(); chk_a("bp0", 1'b1, 32'h11, 1'b0, 1'b1);
        bus_a.ctrl = 2'd1; tick(); chk_a("bp1", 1'b1, 32'h11, 1'b0, 1'b0);
        bus_a.ctrl = 2'd2; tick(); chk_a("bp2", 1'b1, 32'h11, 1'b0, 1'b0);
        tick(); chk_a("bp3", 1'b1, 32'h11, 1'b0, 1'b0);
        bus_a.out_ready = 1'b1;
        tick(); chk_a("bp_pop1", 1'b1, 32'h22, 1'b0, 1'b1);
        tick(); chk_a("bp_pop2", 1'b1, 32'h33, 1'b0, 1'b1);
        bus_a.in_valid = 1'b0;
        tick(); chk_a("bp_drain", 1'b0, 32'h0, 1'b0, 1'b1);

        // Flush on a full buffer with a same-cycle offer
        bus_a.out_ready = 1'b0;
        bus_a.in_valid  = 1'b1;
        bus_a.ctrl = 2'd0; tick();
        bus_a.ctrl = 2'd1; tick(); chk_a("fl_full", 1'b1, 32'h11, 1'b0, 1'b0);
        bus_a.ctrl  = 2'd2;
        bus_a.flush = 1'b1;
        tick(); chk_a("fl", 1'b0, 32'h0, 1'b0, 1'b1);
        bus_a.flush     = 1'b0;
        bus_a.in_valid  = 1'b0;
        bus_a.out_ready = 1'b1;
        tick(); chk_a("fl_after1", 1'b0, 32'h0, 1'b0, 1'b1);
        tick(); chk_a("fl_after2", 1'b0, 32'h0, 1'b0, 1'b1);

        // Flush beats a same-cycle pop and accept
        bus_a.out_ready = 1'b0;
        bus_a.in_valid  = 1'b1;
        bus_a.ctrl = 2'd0; tick(); chk_a("flp_load", 1'b1, 32'h11, 1'b0, 1'b1);
        bus_a.ctrl      = 2'd1;
        bus_a.out_ready = 1'b1;
        bus_a.flush     = 1'b1;
        tick(); chk_a("flp", 1'b0, 32'h0, 1'b0, 1'b1);
        bus_a.flush    = 1'b0;
        bus_a.in_valid = 1'b0;
        tick(); chk_a("flp_after", 1'b0, 32'h0, 1'b0, 1'b1);

        // Reset while two entries are buffered
        bus_a.out_ready = 1'b0;
        bus_a.in_valid  = 1'b1;
        bus_a.ctrl = 2'd1; tick();
        bus_a.ctrl = 2'd3; tick(); chk_a("rs_full", 1'b1, 32'h22, 1'b0, 1'b0);
        reset          = 1'b1;
        bus_a.in_valid = 1'b0;
        tick(); chk_a("rs", 1'b0, 32'h0, 1'b0, 1'b1);
`ifdef MUX_PIPE_ERR_CNT_EN
        chk("rs.erro_cnt", 32'(cnt_a), 32'd0);
`endif
        reset           = 1'b0;
        bus_a.out_ready = 1'b1;
        tick(); chk_a("rs_after1", 1'b0, 32'h0, 1'b0, 1'b1);
        tick(); chk_a("rs_after2", 1'b0, 32'h0, 1'b0, 1'b1);

`ifdef MUX_PIPE_ERR_CNT_EN
        // Saturating illegal-selector counter
        bus_a.ctrl     = 2'd3;
        bus_a.in_valid = 1'b1;
        repeat (10) tick();
        chk("cnt10", 32'(cnt_a), 32'd10);
        chk_a("cnt_entry", 1'b1, 32'h0, 1'b1, 1'b1);
        repeat (290) tick();
        chk("cnt300", 32'(cnt_a), 32'd255);
        bus_a.in_valid = 1'b0;
        bus_a.flush    = 1'b1;
        tick();
        bus_a.flush = 1'b0;
        chk("cnt_flush", 32'(cnt_a), 32'd255);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("cnt_rst", 32'(cnt_a), 32'd0);
        tick();
`endif

        // 16-input sweep, every selector legal
        bus_b.out_ready = 1'b1;
        bus_b.in_valid  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus_b.ctrl = 4'(i);
            tick();
            chk($sformatf("sw%0d.saida", i), 32'(bus_b.saida), 32'(8'hA0 + i));
            chk($sformatf("sw%0d.out_erro", i), 32'(bus_b.out_erro), 32'h0);
            chk($sformatf("sw%0d.out_valid", i), 32'(bus_b.out_valid), 32'h1);
        end
        bus_b.in_valid = 1'b0;
        tick();
        chk("sw_end.out_valid", 32'(bus_b.out_valid), 32'h0);
        chk("sw_end.saida",     32'(bus_b.saida),     32'h0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mux_pipe_n.md
MUX_PIPE_N -- requirements
Module: mux_pipe_n

Interface
REQ-001 Parameter WIDTH, default 32: data width of every input and of the output.
REQ-002 Parameter N_IN, default 3: number of data inputs; legal range 2..16.
REQ-003 Parameter SEL_W, default $clog2(N_IN): width of ctrl. Derived; never overridden.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 clock  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 ctrl  input  SEL_W  input selector, qualified by in_valid.
REQ-008 entradas  input  N_IN*WIDTH  flattened inputs; input i occupies bits [i*WIDTH +: WIDTH].
REQ-009 in_valid  input  1  producer offers ctrl/entradas this cycle.
REQ-010 in_ready  output  1  block can accept this cycle. Registered output.
REQ-011 flush  input  1  discard all buffered entries.
REQ-012 saida  output  WIDTH  selected data.
REQ-013 out_valid  output  1  saida/out_erro hold a valid entry.
REQ-014 out_ready  input  1  consumer takes the entry this cycle.
REQ-015 out_erro  output  1  entry was produced from an illegal ctrl (ctrl >= N_IN).

Function
REQ-016 Accept occurs on a rising edge with in_valid && in_ready && !flush.
REQ-017 Selected value SHALL be input[ctrl] when ctrl < N_IN; otherwise it SHALL be all zeros, with out_erro=1 for that entry.
REQ-018 Latency SHALL be 1 cycle: an entry accepted at edge k drives out_valid/saida from just after edge k.
REQ-019 Storage SHALL be 2 entries: a main output register and a skid register; order SHALL be preserved (FIFO).
REQ-020 in_ready SHALL be 1 iff the skid register is empty; it SHALL be computed from registered state only.
REQ-021 With out_ready held at 1, sustained throughput SHALL be 1 entry per cycle with no bubbles.
REQ-022 Pop occurs when out_valid && out_ready. Pop and accept in the same cycle SHALL leave the occupancy unchanged.
REQ-023 While out_valid && !out_ready, saida and out_erro SHALL hold stable.
REQ-024 Full (2 entries): in_ready=0, and in_valid is ignored. A pop on a full buffer moves the skid entry to main, and in_ready rises on the next cycle.
REQ-025 Flush SHALL empty both entries at the edge; out_valid=0 and in_ready=1 on the next cycle.
REQ-026 Flush SHALL take priority over a same-cycle accept (the input is dropped) and over a pop.
REQ-027 When empty, saida SHALL read 0.

Reset
REQ-028 Reset SHALL take priority over flush and all handshakes.
REQ-029 Reset values SHALL be: out_valid=0, saida=0, out_erro=0, in_ready=1 (first cycle after reset), and erro_cnt=0 when present.
REQ-030 Reset asserted mid-transfer SHALL discard all buffered entries; none appear afterwards.

Configuration
REQ-031 Macro MUX_PIPE_ERR_CNT_EN. When defined, the block SHALL add output erro_cnt (8 bits), which counts accepted illegal-ctrl entries and saturates at 255. Flush SHALL not clear it; only reset clears it.
REQ-032 Without MUX_PIPE_ERR_CNT_EN, the erro_cnt port and counter SHALL be absent; all other behaviour is identical.

Structure
REQ-033 Package mux_pkg SHALL hold MUX_MAX_IN=16, ERR_CNT_W=8, and the entry struct type (data, erro).
REQ-034 Sub-module skid_buf SHALL implement the 2-entry buffer (REQ-019..REQ-026), parameterised by entry width.
REQ-035 The select/decode logic SHALL be combinational, in mux_pipe_n.

Verification
REQ-036 N_IN=3, WIDTH=32. Inputs 0x11, 0x22, 0x33; ctrl=0,1,2,3 on consecutive cycles, out_ready=1. Required: saida = 0x11, 0x22, 0x33, 0x0, one per cycle; out_erro=1 only on the 4th entry.
REQ-037 out_ready=0 while 3 entries are offered. Required: 2 accepted, in_ready=0 from the 3rd cycle, saida frozen at the 1st entry. Then out_ready=1: order 1, 2, then the 3rd is accepted.
REQ-038 Full buffer with flush=1 and in_valid=1 in the same cycle. Required: next cycle out_valid=0, in_ready=1, and the offered entry never appears.
REQ-039 Reset pulsed while 2 entries are buffered. Required: out_valid=0, saida=0 afterwards, and no stale data.
REQ-040 With MUX_PIPE_ERR_CNT_EN defined: 300 illegal-ctrl accepts. Required: erro_cnt=255. A following flush leaves it at 255; reset sets it to 0.
REQ-041 N_IN=16, WIDTH=8. Sweep ctrl 0..15 with input i = i+0xA0. Required: saida = 0xA0..0xAF, never out_erro.
